// File: rtl/light_sequencer.sv
// light_sequencer
// Round-robin traffic-phase generator. Grants one road at a time and walks it
// through GREEN -> YELLOW -> RED, then moves to the next road. It issues
// exactly one write per phase change on the road/light_out/light_valid bus.
// The downstream per-road latch captures light_out for road on the falling
// edge of light_valid.
//
// Ports:
//   clk         - single clock, rising edge
//   reset       - asynchronous, active-high
//   enable      - run request, sampled only in INIT and ADVANCE
//   stop        - early GREEN termination request (ignored at counter 0)
//   light_out   - 3'b001 red, 3'b010 yellow, 3'b100 green
//   road        - road being written
//   light_valid - single-cycle write strobe
//   busy        - high in every state except INIT
module light_sequencer #(
  parameter int states      = 6,
  parameter int roads       = 4,
  parameter int lights      = 5,
  parameter int count_max   = 15,
  parameter int green_time  = 8,
  parameter int yellow_time = 3,
  parameter int clear_time  = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     stop,
  output logic [2:0]               light_out,
  output logic [$clog2(roads)-1:0] road,
  output logic                     light_valid,
  output logic                     busy
);

  localparam int SW = $clog2(states);
  localparam int RW = $clog2(roads);
  localparam int CW = $clog2(count_max + 1);

  localparam logic [2:0] RED_CODE    = 3'b001;
  localparam logic [2:0] YELLOW_CODE = 3'b010;
  localparam logic [2:0] GREEN_CODE  = 3'b100;

  localparam logic [CW-1:0] GREEN_LAST  = CW'(green_time - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(yellow_time - 1);
  localparam logic [CW-1:0] CLEAR_LAST  = CW'(clear_time - 1);
  localparam logic [RW-1:0] ROAD_LAST   = RW'(roads - 1);

  if (green_time  < 2 || green_time  > count_max ||
      yellow_time < 2 || yellow_time > count_max ||
      clear_time  < 2 || clear_time  > count_max) begin : g_bad_timing
    $error("light_sequencer: phase durations must lie in [2, count_max]");
  end

  if (lights != 5 || states < lights) begin : g_bad_states
    $error("light_sequencer: five FSM states required within the state budget");
  end

  typedef enum logic [SW-1:0] {
    INIT,
    GREEN,
    YELLOW,
    RED,
    ADVANCE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] road_next;

  // Explicit compare so a non-power-of-two road count wraps correctly.
  always_comb begin
    road_next = road + 1'b1;
    if (road == ROAD_LAST) road_next = '0;
  end

  // road is advanced on leaving ADVANCE so that, when going on to GREEN,
  // it changes together with the rising light_valid; when dropping to INIT
  // it is already pointing at the road to resume from.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= INIT;
      cnt         <= '0;
      road        <= '0;
      light_out   <= RED_CODE;
      light_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      light_valid <= 1'b0;
      cnt         <= cnt + 1'b1;
      case (state)
        INIT: begin
          cnt <= '0;
          if (enable) begin
            state       <= GREEN;
            light_out   <= GREEN_CODE;
            light_valid <= 1'b1;
            busy        <= 1'b1;
          end
        end
        GREEN: begin
          // stop at counter 0 is ignored so the GREEN strobe always gets a
          // stable low cycle before the next write.
          if (cnt == GREEN_LAST || (stop && cnt != '0)) begin
            state       <= YELLOW;
            cnt         <= '0;
            light_out   <= YELLOW_CODE;
            light_valid <= 1'b1;
          end
        end
        YELLOW: begin
          if (cnt == YELLOW_LAST) begin
            state       <= RED;
            cnt         <= '0;
            light_out   <= RED_CODE;
            light_valid <= 1'b1;
          end
        end
        RED: begin
          if (cnt == CLEAR_LAST) begin
            state <= ADVANCE;
            cnt   <= '0;
          end
        end
        ADVANCE: begin
          cnt  <= '0;
          road <= road_next;
          if (enable) begin
            state       <= GREEN;
            light_out   <= GREEN_CODE;
            light_valid <= 1'b1;
          end else begin
            state <= INIT;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= INIT;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_light_sequencer.sv
// Bench for light_sequencer: default-parameter instance checked against a
// write scoreboard (road, code, cycle), plus a roads=3 instance for wrap.
module tb_light_sequencer;

  localparam logic [2:0] RED_C = 3'b001;
  localparam logic [2:0] YEL_C = 3'b010;
  localparam logic [2:0] GRN_C = 3'b100;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable, stop;
  logic [2:0] light_out;
  logic [1:0] road;
  logic       light_valid, busy;

  logic       enable3, stop3;
  logic [2:0] light_out3;
  logic [1:0] road3;
  logic       light_valid3, busy3;

  light_sequencer dut (
    .clk(clk), .reset(reset), .enable(enable), .stop(stop),
    .light_out(light_out), .road(road), .light_valid(light_valid), .busy(busy)
  );

  light_sequencer #(.roads(3)) dut3 (
    .clk(clk), .reset(reset), .enable(enable3), .stop(stop3),
    .light_out(light_out3), .road(road3), .light_valid(light_valid3), .busy(busy3)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0] rd;
    logic [2:0] code;
    int         at;
  } wr_t;

  wr_t sb[$];
  wr_t sb3[$];

  int checks = 0;
  int fails = 0;
  int cyc = 0;
  int n_writes = 0;
  int n_before = 0;
  int base = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: every strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    wr_t e;
    if (light_valid === 1'b1) begin
      n_writes++;
      checks++;
      if (prev_valid === 1'b1) begin
        fails++;
        $display("FAIL strobe_isolated cyc=%0d got light_valid high twice in a row, required single-cycle", cyc);
      end
      checks++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_write got road=%0d code=%b cyc=%0d, required no write", road, light_out, cyc);
      end else begin
        e = sb.pop_front();
        if (road !== e.rd || light_out !== e.code || cyc !== e.at) begin
          fails++;
          $display("FAIL write got road=%0d code=%b cyc=%0d, required road=%0d code=%b cyc=%0d",
                   road, light_out, cyc, e.rd, e.code, e.at);
        end
      end
    end
    prev_valid = light_valid;
  end

  task automatic push(input logic [1:0] r, input logic [2:0] c, input int at);
    wr_t e;
    e.rd = r; e.code = c; e.at = at;
    sb.push_back(e);
  endtask

  // Return just after the falling edge at which cyc has reached t.
  task automatic settle(input int t);
    do begin
      @(negedge clk);
      #1;
    end while (cyc < t);
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b1; stop = 1'b0; enable3 = 1'b0; stop3 = 1'b0;
    settle(3);
    checks++; if (light_out !== RED_C) begin fails++; $display("FAIL reset_light got %b required %b", light_out, RED_C); end
    checks++; if (road !== 2'd0) begin fails++; $display("FAIL reset_road got %0d required 0", road); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b required 0", busy); end
    checks++; if (light_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b required 0", light_valid); end
    n_before = n_writes;
    reset = 1'b0;
    base = cyc + 1;
    push(2'd0, GRN_C, base);
    settle(base);
    checks++; if (light_valid !== 1'b1 || light_out !== GRN_C || road !== 2'd0) begin
      fails++; $display("FAIL first_green got valid=%b code=%b road=%0d required 1/100/0", light_valid, light_out, road);
    end
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_green got %b required 1", busy); end
    settle(base + 1);
    checks++; if (light_valid !== 1'b0 || light_out !== GRN_C) begin
      fails++; $display("FAIL green_hold got valid=%b code=%b required 0/100", light_valid, light_out);
    end
  endtask

  task automatic test_rotation;
    for (int r = 0; r < 4; r++) begin
      if (r > 0) push(2'(r), GRN_C, base + 14 * r);
      push(2'(r), YEL_C, base + 14 * r + 8);
      push(2'(r), RED_C, base + 14 * r + 11);
    end
    push(2'd0, GRN_C, base + 56);
    settle(base + 55);
    checks++; if (n_writes - n_before !== 12) begin
      fails++; $display("FAIL rotation_pulses got %0d required 12", n_writes - n_before);
    end
    settle(base + 56);
    checks++; if (sb.size() != 0) begin fails++; $display("FAIL rotation_pending got %0d writes outstanding required 0", sb.size()); end
    checks++; if (road !== 2'd0) begin fails++; $display("FAIL road_wrap got %0d required 0", road); end
    base = base + 56;
  endtask

  task automatic test_stop;
    int g2;
    settle(base + 3);
    stop = 1'b1;
    push(2'd0, YEL_C, base + 4);
    push(2'd0, RED_C, base + 7);
    push(2'd1, GRN_C, base + 10);
    settle(base + 4);
    stop = 1'b0;
    checks++; if (light_out !== YEL_C) begin fails++; $display("FAIL stop_yellow got %b required %b", light_out, YEL_C); end
    g2 = base + 10;
    settle(g2);
    stop = 1'b1;
    push(2'd1, YEL_C, g2 + 8);
    push(2'd1, RED_C, g2 + 11);
    push(2'd2, GRN_C, g2 + 14);
    settle(g2 + 1);
    stop = 1'b0;
    settle(g2 + 7);
    checks++; if (light_out !== GRN_C) begin fails++; $display("FAIL stop_cnt0_ignored got %b required %b", light_out, GRN_C); end
    settle(g2 + 14);
    checks++; if (sb.size() != 0) begin fails++; $display("FAIL stop_pending got %0d required 0", sb.size()); end
    base = g2 + 14;
  endtask

  // Road 2: stop coincides with natural expiry, then enable drops in YELLOW.
  task automatic test_enable_drop;
    int gr;
    settle(base + 7);
    stop = 1'b1;
    push(2'd2, YEL_C, base + 8);
    settle(base + 8);
    stop = 1'b0;
    checks++; if (light_out !== YEL_C) begin fails++; $display("FAIL expiry_stop_yellow got %b required %b", light_out, YEL_C); end
    settle(base + 9);
    enable = 1'b0;
    push(2'd2, RED_C, base + 11);
    settle(base + 12);
    checks++; if (busy !== 1'b1) begin fails++; $display("FAIL busy_red got %b required 1", busy); end
    settle(base + 20);
    checks++; if (road !== 2'd3) begin fails++; $display("FAIL drop_road got %0d required 3", road); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL drop_busy got %b required 0", busy); end
    checks++; if (light_out !== RED_C || light_valid !== 1'b0) begin
      fails++; $display("FAIL drop_hold got code=%b valid=%b required 001/0", light_out, light_valid);
    end
    checks++; if (sb.size() != 0) begin fails++; $display("FAIL drop_pending got %0d required 0", sb.size()); end
    enable = 1'b1;
    gr = cyc + 1;
    push(2'd3, GRN_C, gr);
    push(2'd3, YEL_C, gr + 8);
    settle(gr);
    checks++; if (road !== 2'd3 || light_out !== GRN_C) begin
      fails++; $display("FAIL resume got road=%0d code=%b required 3/100", road, light_out);
    end
    base = gr;
  endtask

  task automatic test_async_reset;
    int c;
    settle(base + 8);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    checks++; if (light_out !== RED_C || road !== 2'd0 || light_valid !== 1'b0 || busy !== 1'b0) begin
      fails++; $display("FAIL async_reset got code=%b road=%0d valid=%b busy=%b required 001/0/0/0",
                        light_out, road, light_valid, busy);
    end
    enable = 1'b0;
    settle(cyc + 2);
    reset = 1'b0;
    c = cyc;
    settle(c + 20);
    checks++; if (sb.size() != 0) begin fails++; $display("FAIL reset_pending got %0d required 0", sb.size()); end
    checks++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_idle_busy got %b required 0", busy); end
  endtask

  task automatic test_three_roads;
    int  c3;
    wr_t e;
    enable3 = 1'b1;
    c3 = cyc + 1;
    for (int k = 0; k < 4; k++) begin
      e.rd = 2'(k % 3); e.code = GRN_C; e.at = c3 + 14 * k;
      sb3.push_back(e);
    end
    for (int i = 0; i < 43; i++) begin
      settle(c3 + i);
      checks++;
      if (road3 === 2'd3) begin fails++; $display("FAIL road3_range got 3 at cyc %0d required 0..2", cyc); end
      if (light_valid3 === 1'b1 && light_out3 === GRN_C) begin
        checks++;
        if (sb3.size() == 0) begin
          fails++; $display("FAIL road3_extra got road=%0d cyc=%0d required no green", road3, cyc);
        end else begin
          e = sb3.pop_front();
          if (road3 !== e.rd || cyc !== e.at) begin
            fails++; $display("FAIL road3_seq got road=%0d cyc=%0d required road=%0d cyc=%0d", road3, cyc, e.rd, e.at);
          end
        end
      end
    end
    checks++; if (sb3.size() != 0) begin fails++; $display("FAIL road3_pending got %0d required 0", sb3.size()); end
    enable3 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_stop();
    test_enable_drop();
    test_async_reset();
    test_three_roads();
    settle(cyc + 2);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
